// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: combinational reads, per-port writes with
// highest-index priority, optional hardwired-zero entry and same-cycle forwarding (REGFILE_BYPASS_EN).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  output logic                       wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_WR-1:0] wrValid;
  logic              conflictNext;

  // Writes aimed at a hardwired-zero entry are dropped before they reach storage or conflict logic.
  always_comb begin
    wrValid = '0;
    for (int i = 0; i < NUM_WR; i++)
      wrValid[i] = wr_en[i] &&
                   !((ZERO_REG != 0) && (wr_addr[i*ADDR_W +: ADDR_W] == '0));
  end

  always_comb begin
    conflictNext = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wrValid[i] && wrValid[j] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]))
          conflictNext = 1'b1;
  end

  // Later loop iterations override earlier ones, so the highest-index port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++)
        regs[e] <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        if (wrValid[i])
          regs[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
      wr_conflict <= conflictNext;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (!rst)
        for (int i = 0; i < NUM_WR; i++)
          if (wrValid[i] && (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W]))
            rd_data[k*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
`else
      // Stored contents only; no forwarding path.
`endif
      if ((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0))
        rd_data[k*DATA_W +: DATA_W] = '0;
    end
  end

endmodule
